// File: rtl/hamming_top_level.sv
// SECDED Hamming decoder engine with private byte memory.
// Reads encoded words, corrects/flags errors, writes results back.

module hamming_dmem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] core [0:DEPTH-1];

  // byte write on the rising edge; read is asynchronous
  always_ff @(posedge clk) begin
    if (i_we) begin
      core[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = core[i_addr];

endmodule

module hamming_top_level #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic done
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(NUM_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  // power-up values let a bare req work without reset
  state_t          r_state = IDLE;
  logic [CW-1:0]   r_cnt   = '0;
  logic [7:0]      r_lo    = '0;
  logic [7:0]      r_hi    = '0;
  logic            r_done  = 1'b0;

  state_t          w_next;
  logic [15:0]     w_word;
  logic [3:0]      w_syn;
  logic            w_par;
  logic [10:0]     w_draw;
  logic [10:0]     w_fix;
  logic [10:0]     w_d;
  logic [1:0]      w_flag;
  logic            w_last;
  logic [AW-1:0]   w_off;
  logic [AW-1:0]   w_addr;
  logic            w_we;
  logic [7:0]      w_wdata;
  logic [7:0]      w_rdata;

  hamming_dmem #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) dm1 (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign w_word = {r_hi, r_lo};
  assign w_syn  = {^(w_word & 16'hFF00),
                   ^(w_word & 16'hF0F0),
                   ^(w_word & 16'hCCCC),
                   ^(w_word & 16'hAAAA)};
  assign w_par  = ^w_word;

  assign w_draw = {w_word[15:9], w_word[7:5], w_word[3]};

  // single error on a data position: flip that payload bit
  always_comb begin
    w_fix = '0;
    if (w_par) begin
      unique case (w_syn)
        4'd3:    w_fix[0]  = 1'b1;
        4'd5:    w_fix[1]  = 1'b1;
        4'd6:    w_fix[2]  = 1'b1;
        4'd7:    w_fix[3]  = 1'b1;
        4'd9:    w_fix[4]  = 1'b1;
        4'd10:   w_fix[5]  = 1'b1;
        4'd11:   w_fix[6]  = 1'b1;
        4'd12:   w_fix[7]  = 1'b1;
        4'd13:   w_fix[8]  = 1'b1;
        4'd14:   w_fix[9]  = 1'b1;
        4'd15:   w_fix[10] = 1'b1;
        default: w_fix     = '0;
      endcase
    end
  end

  assign w_d = w_draw ^ w_fix;

  // status: 01 single (corrected), 10 double, 00 clean
  always_comb begin
    w_flag = 2'b00;
    if (w_par) begin
      w_flag = 2'b01;
    end else if (w_syn != 4'd0) begin
      w_flag = 2'b10;
    end
  end

  assign w_last = (r_cnt == CW'(NUM_WORDS - 1));
  assign w_off  = AW'({r_cnt, 1'b0});

  // next state, memory address and write strobe
  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_wdata = '0;
    w_addr  = AW'(SRC_BASE) + w_off;
    unique case (r_state)
      IDLE: begin
        if (req) w_next = RD_LO;
      end
      RD_LO: begin
        w_next = RD_HI;
      end
      RD_HI: begin
        w_addr = AW'(SRC_BASE) + w_off + AW'(1);
        w_next = WR_LO;
      end
      WR_LO: begin
        w_addr  = AW'(DST_BASE) + w_off;
        w_we    = 1'b1;
        w_wdata = w_d[7:0];
        w_next  = WR_HI;
      end
      WR_HI: begin
        w_addr  = AW'(DST_BASE) + w_off + AW'(1);
        w_we    = 1'b1;
        w_wdata = {w_flag, 3'b000, w_d[10:8]};
        w_next  = w_last ? DONE : RD_LO;
      end
      DONE: begin
        if (req) w_next = RD_LO;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // word counter, byte latches and registered done
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_lo   <= '0;
      r_hi   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      if ((r_state == IDLE || r_state == DONE) && req) begin
        r_cnt <= '0;
      end else if (r_state == WR_HI && !w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == RD_LO) r_lo <= w_rdata;
      if (r_state == RD_HI) r_hi <= w_rdata;
    end
  end

  assign done = r_done;

endmodule

// File: tb/tb_hamming_top_level.sv
// Scoreboard bench for hamming_top_level.
// Expected results come from an index-XOR Hamming model.

module tb_hamming_top_level;

  localparam int N   = 15;
  localparam int SRC = 30;
  localparam int DST = 0;
  localparam int LAT = 4 * N + 1;

  logic clk;
  logic reset;
  logic req;
  logic done;

  int checks;
  int errors;
  int cyc;
  int e0;

  logic [15:0] src_w [N];
  logic [15:0] exp_w [N];
  logic [15:0] exp_q [$];
  int          exp_t_q [$];

  hamming_top_level dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [10:0] d);
    logic [15:0] w;
    int j;
    int s;
    w = '0;
    j = 0;
    s = 0;
    for (int k = 1; k < 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        w[k] = d[j];
        if (d[j]) s = s ^ k;
        j++;
      end
    end
    for (int b = 0; b < 4; b++) w[1 << b] = s[b];
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [15:0] ref_dec(input logic [15:0] wi);
    logic [15:0] w;
    logic [10:0] d;
    logic [1:0]  f;
    int s;
    int j;
    w = wi;
    s = 0;
    for (int k = 0; k < 16; k++) if (w[k]) s = s ^ k;
    if ($countones(w) % 2 == 1) begin
      f = 2'b01;
      w[s] = ~w[s];
    end else if (s != 0) begin
      f = 2'b10;
    end else begin
      f = 2'b00;
    end
    j = 0;
    d = '0;
    for (int k = 1; k < 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        d[j] = w[k];
        j++;
      end
    end
    return {f, 3'b000, d};
  endfunction

  function automatic logic [15:0] get_dst(input int i);
    return {dut.dm1.core[DST + 2 * i + 1],
            dut.dm1.core[DST + 2 * i]};
  endfunction

  task automatic chk(input string nm,
                     input logic [15:0] got,
                     input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic load_src();
    for (int i = 0; i < N; i++) begin
      dut.dm1.core[SRC + 2 * i]     = src_w[i][7:0];
      dut.dm1.core[SRC + 2 * i + 1] = src_w[i][15:8];
    end
  endtask

  task automatic pulse_req();
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    req = 1'b0;
  endtask

  task automatic launch();
    pulse_req();
    for (int i = 0; i < N; i++) exp_q.push_back(exp_w[i]);
    exp_t_q.push_back(e0 + LAT);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!done && k < 200);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got 0 want 1");
    end
  endtask

  // monitor: on each rising done, pop and compare the job results
  initial begin
    logic prev;
    int   t;
    prev = 1'b0;
    cyc  = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (done && !prev) begin
        checks++;
        if (exp_t_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected got 1 want 0 cyc %0d", cyc);
        end else begin
          t = exp_t_q.pop_front();
          if (cyc != t) begin
            errors++;
            $display("FAIL done_latency got %0d want %0d", cyc, t);
          end
          for (int i = 0; i < N; i++) begin
            if (exp_q.size() > 0) chk("result", get_dst(i), exp_q.pop_front());
          end
        end
      end
      prev = done;
    end
  end

  initial begin
    logic [10:0] d;
    int a;
    int b;
    checks = 0;
    errors = 0;
    req    = 1'b0;
    reset  = 1'b0;

    // power-up, no reset applied
    @(posedge clk);
    #1;
    chk("powerup_done", 16'(done), 16'h0);

    // job A: all clean 0xFFFF
    for (int i = 0; i < N; i++) begin
      src_w[i] = 16'hFFFF;
      exp_w[i] = 16'h07FF;
    end
    load_src();
    launch();
    wait_done();

    // job B: directed words + single flips at 0..11
    src_w[0] = 16'h0020;
    exp_w[0] = 16'h4000;
    src_w[1] = 16'hFFFE;
    exp_w[1] = 16'h47FF;
    src_w[2] = 16'h0208;
    exp_w[2] = 16'h8011;
    for (int i = 3; i < N; i++) begin
      d = 11'($urandom);
      src_w[i] = enc(d) ^ (16'h1 << (i - 3));
      exp_w[i] = {5'b01000, d};
    end
    load_src();
    launch();
    wait_done();

    // job C: single flips at 12..15 then double flips
    for (int i = 0; i < 4; i++) begin
      d = 11'($urandom);
      src_w[i] = enc(d) ^ (16'h1 << (i + 12));
      exp_w[i] = {5'b01000, d};
    end
    for (int i = 4; i < N; i++) begin
      d = 11'($urandom);
      a = $urandom_range(15, 0);
      do b = $urandom_range(15, 0); while (b == a);
      src_w[i] = enc(d) ^ (16'h1 << a) ^ (16'h1 << b);
      exp_w[i] = ref_dec(src_w[i]);
      chk("double_msb", 16'(exp_w[i][15]), 16'h1);
    end
    load_src();
    launch();
    wait_done();

    // job D: random mix, reset during word 7
    for (int i = 0; i < 2 * N; i++) dut.dm1.core[DST + i] = 8'hA5;
    for (int i = 0; i < N; i++) begin
      src_w[i] = enc(11'($urandom));
      a = $urandom_range(2, 0);
      if (a >= 1) src_w[i] = src_w[i] ^ (16'h1 << $urandom_range(15, 0));
      if (a == 2) src_w[i] = src_w[i] ^ (16'h1 << $urandom_range(15, 0));
      exp_w[i] = ref_dec(src_w[i]);
    end
    load_src();
    pulse_req();
    repeat (28) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_done", 16'(done), 16'h0);
    for (int i = 0; i < 7; i++) chk("kept_word", get_dst(i), exp_w[i]);
    for (int i = 7; i < N; i++) chk("unwritten", get_dst(i), 16'hA5A5);
    repeat (8) @(posedge clk);
    #1;
    chk("idle_done", 16'(done), 16'h0);
    chk("idle_nowrite", get_dst(7), 16'hA5A5);

    // job E: full rerun with an ignored req while busy
    launch();
    repeat (10) @(posedge clk);
    pulse_req();
    wait_done();

    // job F: req while in DONE restarts the job
    launch();
    @(posedge clk);
    #1;
    chk("done_clear", 16'(done), 16'h0);
    wait_done();

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drain", 16'(exp_t_q.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming_top_level.md
Name:
hamming_top_level

Overview:
- Self-contained SECDED Hamming decoder engine: top_level in the design, instantiated as DUT.
- On a `req` pulse it reads 15 encoded 16-bit words from its internal byte-wide data memory.
- For each word it detects and corrects single-bit errors, flags double-bit errors, and writes the 11-bit payload plus 2-bit status back to memory.
- Memory is backdoor-loaded and inspected by the bench.

Parameters:
- NUM_WORDS, 15: number of encoded words processed per request.
- SRC_BASE, 30: byte address of the first encoded word (low byte).
- DST_BASE, 0: byte address of the first result word (low byte).
- MEM_DEPTH, 256: data memory depth in bytes.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  start pulse; sampled on a rising clk edge.
- done  output  1  high when all NUM_WORDS results are written.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Memory: internal instance named `dm1` containing array `core[0:MEM_DEPTH-1]` of 8-bit bytes.
  - Combinational read, synchronous write, one access per cycle.
  - Not cleared by reset; contents survive reset and req.
  - Hierarchical names `dm1.core` are fixed for backdoor access.
- Source word i (0..14):
  - Low byte at SRC_BASE+2i, high byte at SRC_BASE+2i+1.
  - w = {hi, lo}.
- Encoded layout (bit index = Hamming position):
  - w[15:9] = d[11:5], w[8] = p8, w[7:5] = d[4:2], w[4] = p4, w[3] = d[1], w[2] = p2, w[1] = p1, w[0] = p0 (overall parity).
- Syndrome:
  - s1 = XOR of w[k] for k with k[0]=1.
  - s2, s4, s8 likewise, for k[1], k[2], k[3] set.
  - S = {s8, s4, s2, s1}; P = XOR of all 16 bits.
- Classification:
  - S=0, P=0: no error, flag F=2'b00.
  - P=1: single error, flag 2'b01; invert w[S]. S=0 means p0 itself flipped, so data is unchanged.
  - P=0, S≠0: double error, flag 2'b10; data output uncorrected.
- Result word i:
  - Low byte d[8:1] written to DST_BASE+2i.
  - High byte {F[1:0], 3'b000, d[11:9]} written to DST_BASE+2i+1.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
  - IDLE: if req, go to RD_LO with word counter = 0.
  - RD_LO: latch low byte.
  - RD_HI: latch high byte.
  - WR_LO: write low result byte.
  - WR_HI: write high result byte; if counter = NUM_WORDS-1 go to DONE, else increment counter and go to RD_LO.
  - DONE: done=1; held until reset or a new req, which restarts at RD_LO and clears done the following cycle.
- Latency: 4 cycles per word. done rises 4*NUM_WORDS+1 = 61 cycles after the req edge.
- req asserted while busy (RD_LO..WR_HI) is ignored.
- Reset (any state, including mid-operation):
  - state=IDLE, counter=0, done=0, latched bytes=0.
  - Partially written results remain in memory.
- Power-up (no reset applied): state registers initialise to IDLE, done=0, so a bare req pulse works.
- Decode logic is purely combinational from the latched bytes. No memory writes occur outside WR_LO/WR_HI.

Test Plan:
- All 15 words = 0xFFFF (d=11'h7FF, no error), req pulse -> each result 0x07FF (hi 0x07, lo 0xFF); done high 61 cycles after req.
- Word 0x0020 (d=0, bit 5 flipped) -> result 0x4000. Word 0xFFFE (p0 flipped, d=7FF) -> result 0x47FF.
- Word 0x0208 (d=0, bits 3 and 9 flipped) -> result high byte MSB=1, i.e. 0x80xx.
- Random d with one flip in each of positions 0..15 -> {5'b01000, d} every time; two distinct flips -> hi[7]=1.
- Assert reset mid-run (word 7) -> done=0 and state IDLE next cycle, memory kept. A new req processes all 15 words correctly.
- req pulse while busy -> ignored, done timing unchanged. req in DONE -> reprocesses, done drops then re-rises 61 cycles later.
